// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: PC sequencer issuing fetch requests with held redirects across memory stalls.
// Optional stall counter is built when FETCH_ISSUE_STALL_COUNT_EN is defined.
module fetch_issue_unit #(
    parameter int CORE            = 0,
    parameter int ADDRESS_BITS    = 20,
    parameter int RESET_PC        = 0,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              next_PC_select,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    input  logic                    i_mem_read,
    input  logic                    fetch_ready,
    input  logic                    scan,
    output logic                    fetch_read,
    output logic [ADDRESS_BITS-1:0] fetch_address_out,
    output logic [ADDRESS_BITS-1:0] issue_PC,
    output logic [31:0]             stall_count
);
    typedef enum logic [1:0] {S_RESET, S_RUN, S_WAIT} state_t;
    state_t                  r_state, w_state_nxt;
    logic [ADDRESS_BITS-1:0] r_pc, r_issue, r_redirect, w_pc_nxt;
    logic                    r_pending;
    logic [31:0]             r_cycle;
    logic                    w_accept, w_sel_target;
    // Reset gates the request combinationally so nothing completes while it is held.
    assign fetch_read        = (r_state != S_RESET) && !reset && i_mem_read;
    assign w_accept          = fetch_read && fetch_ready;
    assign w_sel_target      = next_PC_select == 2'b10;
    assign fetch_address_out = r_pc;
    assign issue_PC          = r_issue;
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (r_state == S_RESET)
            w_state_nxt = S_RUN;
        else if (w_accept) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = r_pending                  ? r_redirect :
                          next_PC_select == 2'b00    ? r_pc + ADDRESS_BITS'(4) :
                          w_sel_target               ? target_PC : r_pc;
        end else
            w_state_nxt = fetch_read ? S_WAIT : S_RUN;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_RESET;
            r_pc       <= ADDRESS_BITS'(RESET_PC);
            r_issue    <= ADDRESS_BITS'(RESET_PC);
            r_redirect <= '0;
            r_pending  <= 1'b0;
            r_cycle    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cycle <= r_cycle + 32'd1;
            if (w_accept) begin
                r_issue   <= r_pc;
                r_pending <= 1'b0;
            end else if (r_state != S_RESET && w_sel_target) begin
                r_redirect <= target_PC;
                r_pending  <= 1'b1;
            end
        end
    end
`ifdef FETCH_ISSUE_STALL_COUNT_EN
    logic [31:0] r_stall;
    always_ff @(posedge clock) begin
        if (reset)
            r_stall <= '0;
        else if (fetch_read && !fetch_ready)
            r_stall <= r_stall + 32'd1;
    end
    assign stall_count = r_stall;
`else
    assign stall_count = 32'd0;
`endif
`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (scan && r_cycle >= 32'(SCAN_CYCLES_MIN) && r_cycle <= 32'(SCAN_CYCLES_MAX))
            $display("core %0d state %0d pc %h issue %h pending %0d",
                     CORE, r_state, r_pc, r_issue, r_pending);
    end
`endif
endmodule

// File: doc/fetch_issue_unit.md
FETCH_ISSUE_UNIT -- requirements
Module: fetch_issue_unit

Interface
REQ-001 SHALL have parameter CORE, 0, core index printed in scan output.
REQ-002 SHALL have parameter ADDRESS_BITS, 20, PC and address width.
REQ-003 SHALL have parameter RESET_PC, 0, first fetch address after reset.
REQ-004 SHALL have parameters SCAN_CYCLES_MIN, 0, and SCAN_CYCLES_MAX, 1000, the cycle window for scan printing.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port next_PC_select  input  2  from control unit: 00 PC+4, 01 hold, 10 target, 11 reserved (treated as hold).
REQ-008 SHALL have port target_PC  input  ADDRESS_BITS  redirect address, used when select=10.
REQ-009 SHALL have port i_mem_read  input  1  control-unit fetch enable.
REQ-010 SHALL have port fetch_ready  input  1  instruction memory accepts request this cycle.
REQ-011 SHALL have port scan  input  1  enables debug printing.
REQ-012 SHALL have port fetch_read  output  1  request valid to instruction memory.
REQ-013 SHALL have port fetch_address_out  output  ADDRESS_BITS  request address (current PC register).
REQ-014 SHALL have port issue_PC  output  ADDRESS_BITS  address of the most recently accepted request.
REQ-015 SHALL have port stall_count  output  32  cycles with fetch_read=1 and fetch_ready=0.

Function
REQ-016 SHALL implement states RESET, RUN, WAIT in a 2-bit register.
REQ-017 RESET: fetch_read=0, PC=RESET_PC; one cycle after reset deasserts -> RUN.
REQ-018 RUN/WAIT: fetch_read SHALL equal i_mem_read; fetch_address_out SHALL equal PC register.
REQ-019 Acceptance SHALL be fetch_read & fetch_ready; on acceptance issue_PC <= PC on the same edge.
REQ-020 On acceptance, PC SHALL update next edge: 00 -> PC+4, 10 -> target_PC, 01/11 -> hold; pending redirect overrides select.
REQ-021 PC+4 SHALL wrap modulo 2^ADDRESS_BITS, with no saturation and no flag.
REQ-022 fetch_read=1 with fetch_ready=0 -> WAIT; PC and fetch_address_out SHALL stay stable until acceptance.
REQ-023 select=10 without acceptance SHALL latch target_PC into redirect_PC and set pending=1; a later select=10 SHALL overwrite it (newest wins).
REQ-024 On acceptance with pending=1: PC <= redirect_PC, pending <= 0, state -> RUN.
REQ-025 Simultaneous acceptance and select=10 with pending=0 SHALL load target_PC directly and leave pending=0.
REQ-026 fetch_read=0 (i_mem_read low) SHALL not advance PC; a select=10 in that cycle SHALL set pending.
REQ-027 When scan=1 and cycle counter is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], the block SHALL print CORE, state, PC, issue_PC and pending each cycle (simulation only).

Reset
REQ-028 Reset SHALL set state=RESET, PC=RESET_PC, issue_PC=RESET_PC, redirect_PC=0, pending=0, stall_count=0, cycle counter=0.
REQ-029 Reset asserted mid-WAIT or with pending=1 SHALL discard the outstanding request and the redirect, with no memory transaction completing.
REQ-030 fetch_read SHALL be 0 while reset is high and for one cycle after.

Configuration
REQ-031 Macro FETCH_ISSUE_STALL_COUNT_EN defined: stall_count increments per stall cycle, wrapping at 2^32.
REQ-032 Macro undefined: the counter is not built and stall_count is tied to 0; all other behaviour is identical.

Verification
REQ-033 Reset with RESET_PC=0, then i_mem_read=1, fetch_ready=1, select=00 for 3 cycles -> fetch_address_out 0,4,8; issue_PC 0,4,8 one edge later.
REQ-034 fetch_ready=0 for 2 cycles at PC=8 with select=00 -> address holds 8, state WAIT, stall_count=2 (macro on) or 0 (macro off).
REQ-035 At PC=8 with fetch_ready=0: select=10 with target 12, then target 20 -> on fetch_ready=1, request 8 is accepted and the next address is 20.
REQ-036 select=10 with target 12 and acceptance in the same cycle -> next address 12, pending=0.
REQ-037 ADDRESS_BITS=20, PC=0xFFFFC, select=00, accepted -> next address 0x00000.
REQ-038 Reset asserted during WAIT with pending=1 -> fetch_read=0 for 2 cycles, then address equals RESET_PC and pending=0.
